soc_clkrst_seq: RTL and testbench
=================================

// Module: soc_clkrst_seq
// PURPOSE
// - Startup/recovery sequencer for the SoC clock and reset. Sits between the board clock input
//   buffer and the BUFGCE feeding the soft SoC; drives the buffer CE and the SoC reset.
// - Orders bring-up as: source lock stable -> clock enabled -> reset released. Tear-down runs in
//   the reverse order. Also handles software-requested SoC resets and lock-loss recovery.
// PARAMETERS
// - SYNC_STAGES    2     flops in the lock_in synchronizer (>=2)
// - SETTLE_CYCLES  1024  cycles lock must stay high before the clock is enabled (>=1)
// - CE_LEAD_CYCLES 16    cycles buf_ce leads soc_reset deassert (>=1)
// - SW_RST_CYCLES  64    soc_reset pulse width for a software reset (>=1)
// - CNT_W          16    shared down-counter width; every *_CYCLES value must be < 2**CNT_W
// PORTS
// - clk            in   1  free-running clock from the input buffer; single clock domain
// - reset          in   1  synchronous, active-high block reset
// - lock_in        in   1  asynchronous clock-source lock/valid; synchronized internally
// - sw_reset_req   in   1  level, clk domain; SoC-requested reset, sampled only in RUN
// - buf_ce         out  1  enable for the SoC BUFGCE
// - soc_reset      out  1  synchronous active-high reset to the SoC
// - ready          out  1  high only in RUN
// - state_o        out  3  current state encoding (debug/LED)
// - lock_loss_cnt  out  8  saturating count of lock-loss events (stops at 255)
// BEHAVIOUR
// - States: WAIT_LOCK=0, SETTLE=1, CLK_EN=2, RUN=3, SW_RST=4, SHUTDOWN=5. Codes 6/7 go to WAIT_LOCK.
// - Moore outputs, decoded from the registered state (no extra cycle of latency):
//   - buf_ce = 1 in CLK_EN, RUN, SW_RST and SHUTDOWN.
//   - soc_reset = 1 in every state except RUN.
//   - ready = (state==RUN).
// - Reset values: state WAIT_LOCK, buf_ce 0, soc_reset 1, ready 0, state_o 0, lock_loss_cnt 0,
//   counter 0, synchronizer flops 0.
// - lock_s is lock_in after SYNC_STAGES flops; all decisions use lock_s only.
// - Counter: one CNT_W down-counter, loaded with N-1 on the transition into a timed state.
//   The state exits on the cycle the counter reads 0, so the timed state lasts exactly N cycles.
// - Transitions:
//   - WAIT_LOCK: lock_s=1 -> SETTLE (load SETTLE_CYCLES-1).
//   - SETTLE:    lock_s=0 -> WAIT_LOCK (counter dropped); cnt==0 -> CLK_EN (load CE_LEAD_CYCLES-1).
//   - CLK_EN:    lock_s=0 -> SHUTDOWN; cnt==0 -> RUN.
//   - RUN:       lock_s=0 -> SHUTDOWN; else sw_reset_req=1 -> SW_RST (load SW_RST_CYCLES-1).
//   - SW_RST:    lock_s=0 -> SHUTDOWN; cnt==0 -> RUN. buf_ce stays 1 throughout.
//   - SHUTDOWN:  exactly 1 cycle (soc_reset=1 with buf_ce=1), then WAIT_LOCK (buf_ce=0).
//     Reset is therefore always asserted at least one edge before the clock is gated.
// - Priority: lock loss beats sw_reset_req and beats counter expiry in the same cycle.
// - sw_reset_req is ignored outside RUN. If it is still high on return to RUN, RUN lasts 1 cycle
//   and SW_RST is entered again. This is intended: the request is a level.
// - lock_loss_cnt increments on every transition into SHUTDOWN and on SETTLE->WAIT_LOCK;
//   it holds at 255 once saturated.
// - Block reset mid-operation: next edge forces WAIT_LOCK, buf_ce 0, soc_reset 1. Abrupt clock
//   gating is accepted here, because reset implies the SoC is being reset anyway.
// - Minimum bring-up latency from lock_in rise to ready:
//   SYNC_STAGES + 1 + SETTLE_CYCLES + CE_LEAD_CYCLES cycles.
// STRUCTURE
// - Shared package clkrst_pkg: state encoding localparams, STATE_W=3, LOSS_CNT_W=8.
// - Sub-module sync_ff (parameter STAGES, 1-bit, reset to 0) instantiated for lock_in.
//   Everything else (FSM, counter, outputs) lives in this module.
// TESTING (bench params: SYNC_STAGES=2, SETTLE=8, CE_LEAD=4, SW_RST=3)
// - Clean bring-up: reset 1->0, lock_in rises at cycle 10 -> buf_ce rises at cycle 21,
//   soc_reset falls and ready rises at cycle 25; state_o walks 0,1,2,3.
// - Lock glitch in SETTLE: lock_in low for 3 cycles mid-settle -> back to WAIT_LOCK, buf_ce never
//   rises, lock_loss_cnt=1; full 8-cycle settle is restarted after lock returns.
// - SW reset: 1-cycle sw_reset_req in RUN -> soc_reset high for exactly 3 cycles, buf_ce held 1,
//   then RUN. A held request gives repeated 3-on/1-off soc_reset pulses.
// - Lock loss in RUN: soc_reset=1 on the first cycle with buf_ce still 1, buf_ce=0 on the next
//   cycle, state 3->5->0, lock_loss_cnt+1.
// - Simultaneous lock loss + sw_reset_req in RUN -> SHUTDOWN, never SW_RST. Reset asserted in
//   CLK_EN -> next edge WAIT_LOCK with buf_ce=0 and soc_reset=1.
// - Saturation: force 300 lock-loss events -> lock_loss_cnt reads 255 and stays there.

Source files
------------

// File: rtl/clkrst_pkg.sv
// Shared encodings for the SoC clock/reset sequencer.
package clkrst_pkg;
  localparam int STATE_W    = 3;
  localparam int LOSS_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_CLK_EN    = 3'd2,
    ST_RUN       = 3'd3,
    ST_SW_RST    = 3'd4,
    ST_SHUTDOWN  = 3'd5
  } state_e;
endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level, cleared to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/soc_clkrst_seq.sv
// Clock-enable / SoC-reset sequencer: lock stable -> clock on -> reset released,
// torn down in reverse, with software reset pulses and lock-loss recovery.
//
// state     | meaning
// WAIT_LOCK | clock gated, SoC in reset, waiting for synchronized lock
// SETTLE    | lock seen, must stay high SETTLE_CYCLES before enabling the clock
// CLK_EN    | clock running, SoC still in reset for CE_LEAD_CYCLES
// RUN       | clock running, SoC out of reset
// SW_RST    | software-requested reset pulse, clock kept running
// SHUTDOWN  | one cycle of reset with the clock still on before gating
module soc_clkrst_seq
  import clkrst_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 1024,
  parameter int CE_LEAD_CYCLES = 16,
  parameter int SW_RST_CYCLES  = 64,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lock_in,
  input  logic                  sw_reset_req,
  output logic                  buf_ce,
  output logic                  soc_reset,
  output logic                  ready,
  output logic [STATE_W-1:0]    state_o,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CE_LD     = CNT_W'(CE_LEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LD     = CNT_W'(SW_RST_CYCLES - 1);

  logic                  lock_s;
  logic                  loss_evt;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (lock_in),
    .q     (lock_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: if (lock_s) begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (!lock_s) begin
          state_d  = ST_WAIT_LOCK;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_CLK_EN;
          cnt_d   = CE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // CLK_EN and SW_RST share the same exit rule: lock loss first, then expiry.
      ST_CLK_EN, ST_SW_RST: begin
        if (!lock_s) begin
          state_d  = ST_SHUTDOWN;
          loss_evt = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_SHUTDOWN;
          loss_evt = 1'b1;
        end else if (sw_reset_req) begin
          state_d = ST_SW_RST;
          cnt_d   = SW_LD;
        end
      end
      ST_SHUTDOWN: state_d = ST_WAIT_LOCK;
      default:     state_d = ST_WAIT_LOCK;
    endcase
  end

  always_comb begin
    loss_d = loss_q;
    if (loss_evt && (loss_q != '1)) loss_d = loss_q + LOSS_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
    end
  end

  assign buf_ce        = (state_q == ST_CLK_EN) || (state_q == ST_RUN) ||
                         (state_q == ST_SW_RST) || (state_q == ST_SHUTDOWN);
  assign soc_reset     = (state_q != ST_RUN);
  assign ready         = (state_q == ST_RUN);
  assign state_o       = state_q;
  assign lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_soc_clkrst_seq.sv
// Directed bench for soc_clkrst_seq with a cycle-level reference model and literal spot checks.
module tb_soc_clkrst_seq;
  localparam int SYNC   = 2;
  localparam int SETTLE = 8;
  localparam int CE     = 4;
  localparam int SWR    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lock_in = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       buf_ce, soc_reset, ready;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  soc_clkrst_seq #(
    .SYNC_STAGES    (SYNC),
    .SETTLE_CYCLES  (SETTLE),
    .CE_LEAD_CYCLES (CE),
    .SW_RST_CYCLES  (SWR),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lock_in       (lock_in),
    .sw_reset_req  (sw_reset_req),
    .buf_ce        (buf_ce),
    .soc_reset     (soc_reset),
    .ready         (ready),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: lock is seen SYNC edges late; timed phases count elapsed cycles upward.
  int   m_st = 0;
  int   m_el = 0;
  int   m_loss = 0;
  bit   m_valid = 1'b0;
  logic m_ls;
  logic lq[$];

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_el = 0; m_loss = 0; m_valid = 1'b1;
      lq = {};
      for (int k = 0; k < SYNC; k++) lq.push_back(1'b0);
    end else if (m_valid) begin
      m_ls = lq.pop_front();
      lq.push_back(lock_in);
      case (m_st)
        0: if (m_ls) begin m_st = 1; m_el = 1; end
        1: if (!m_ls) begin m_st = 0; m_loss = sat_inc(m_loss); end
           else if (m_el == SETTLE) begin m_st = 2; m_el = 1; end
           else m_el++;
        2: if (!m_ls) begin m_st = 5; m_loss = sat_inc(m_loss); end
           else if (m_el == CE) m_st = 3;
           else m_el++;
        3: if (!m_ls) begin m_st = 5; m_loss = sat_inc(m_loss); end
           else if (sw_reset_req) begin m_st = 4; m_el = 1; end
        4: if (!m_ls) begin m_st = 5; m_loss = sat_inc(m_loss); end
           else if (m_el == SWR) m_st = 3;
           else m_el++;
        default: m_st = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [13:0] exp_v, act_v;
      exp_v = {(m_st >= 2 && m_st <= 5), (m_st != 3), (m_st == 3), 3'(m_st), 8'(m_loss)};
      act_v = {buf_ce, soc_reset, ready, state_o, lock_loss_cnt};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model t=%0t: dut ce=%b rst=%b rdy=%b st=%0d loss=%0d, model ce=%b rst=%b rdy=%b st=%0d loss=%0d",
                 $time, buf_ce, soc_reset, ready, state_o, lock_loss_cnt,
                 exp_v[13], exp_v[12], exp_v[11], exp_v[10:8], exp_v[7:0]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int max);
    int i = 0;
    while (state_o !== s && i < max) begin
      @(negedge clk);
      i++;
    end
    chk(nm, state_o, s);
  endtask

  // Raise lock and time buf_ce / ready in cycles; record the sequence of visited states.
  task automatic bringup(output int t_ce, output int t_rdy, output logic [15:0] walk);
    logic [2:0] last;
    t_ce = -1; t_rdy = -1;
    walk = {13'b0, state_o};
    last = state_o;
    lock_in = 1'b1;
    for (int i = 1; i <= 40 && t_rdy < 0; i++) begin
      @(negedge clk);
      if (state_o !== last) begin
        walk = {walk[11:0], 1'b0, state_o};
        last = state_o;
      end
      if (t_ce < 0 && buf_ce === 1'b1) t_ce = i;
      if (ready === 1'b1) t_rdy = i;
    end
  endtask

  initial begin
    int t_ce, t_rdy, hi, ce_ok, ce_seen;
    logic [15:0] walk;

    cyc(3);
    chk("reset_state", state_o, 0);
    chk("reset_buf_ce", buf_ce, 0);
    chk("reset_soc_reset", soc_reset, 1);
    chk("reset_ready", ready, 0);
    chk("reset_loss_cnt", lock_loss_cnt, 0);
    reset = 1'b0;
    cyc(7);

    bringup(t_ce, t_rdy, walk);
    chk("bringup_ce_latency", t_ce, 11);
    chk("bringup_ready_latency", t_rdy, 15);
    chk("bringup_state_walk", walk, 16'h0123);

    cyc(2);
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
    hi = 0; ce_ok = 1;
    for (int i = 0; i < 10; i++) begin
      if (soc_reset) hi++;
      if (!buf_ce) ce_ok = 0;
      @(negedge clk);
    end
    chk("sw_pulse_width", hi, 3);
    chk("sw_pulse_ce_held", ce_ok, 1);
    chk("sw_pulse_back_to_run", ready, 1);

    sw_reset_req = 1'b1;
    @(negedge clk);
    hi = 0; ce_ok = 1;
    for (int i = 0; i < 16; i++) begin
      if (soc_reset) hi++;
      if (!buf_ce) ce_ok = 0;
      @(negedge clk);
    end
    chk("sw_held_reset_cycles_of_16", hi, 12);
    chk("sw_held_ce_held", ce_ok, 1);
    sw_reset_req = 1'b0;
    wait_state("sw_held_return_run", 3'd3, 10);

    lock_in = 1'b0;
    wait_state("run_loss_shutdown", 3'd5, 10);
    chk("run_loss_ce_still_on", buf_ce, 1);
    chk("run_loss_reset_on", soc_reset, 1);
    @(negedge clk);
    chk("run_loss_wait_lock", state_o, 0);
    chk("run_loss_ce_off", buf_ce, 0);
    chk("run_loss_count", lock_loss_cnt, 1);

    cyc(3);
    lock_in = 1'b1;
    wait_state("glitch_enter_settle", 3'd1, 10);
    cyc(3);
    lock_in = 1'b0;
    ce_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (buf_ce !== 1'b0) ce_seen = 1;
    end
    chk("glitch_ce_never_on", ce_seen, 0);
    chk("glitch_back_to_wait", state_o, 0);
    chk("glitch_loss_count", lock_loss_cnt, 2);
    bringup(t_ce, t_rdy, walk);
    chk("glitch_restart_ce_latency", t_ce, 11);
    chk("glitch_restart_ready_latency", t_rdy, 15);

    cyc(2);
    lock_in = 1'b0;
    cyc(2);
    sw_reset_req = 1'b1;
    @(negedge clk);
    chk("simul_loss_beats_sw", state_o, 5);
    chk("simul_loss_count", lock_loss_cnt, 3);
    sw_reset_req = 1'b0;
    wait_state("simul_to_wait", 3'd0, 5);

    cyc(3);
    lock_in = 1'b1;
    wait_state("rst_mid_clk_en", 3'd2, 30);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", state_o, 0);
    chk("rst_mid_ce", buf_ce, 0);
    chk("rst_mid_soc_reset", soc_reset, 1);
    chk("rst_mid_loss_cleared", lock_loss_cnt, 0);
    reset = 1'b0;
    lock_in = 1'b0;
    cyc(4);

    for (int i = 0; i < 300; i++) begin
      lock_in = 1'b1; cyc(2);
      lock_in = 1'b0; cyc(2);
    end
    cyc(4);
    chk("sat_loss_count", lock_loss_cnt, 255);
    chk("sat_model_count", m_loss, 255);
    for (int i = 0; i < 5; i++) begin
      lock_in = 1'b1; cyc(2);
      lock_in = 1'b0; cyc(2);
    end
    cyc(4);
    chk("sat_loss_holds", lock_loss_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule
